hp_fetch: RTL and testbench

Instruction fetch stage directly upstream of decode/immgen. Generates sequential word-addressed fetch PCs, issues requests to instruction memory over a req/gnt + rvalid interface, buffers returned instructions in a small prefetch FIFO, and presents {pc, inst} to decode with a valid/ready handshake. A redirect input from branch/jump resolution flushes the buffer, discards in-flight responses and restarts fetch at a new PC.

---
 rtl/hp_pkg.sv | 21 ++
 rtl/hp_fifo.sv | 67 ++++++
 rtl/hp_fetch.sv | 144 ++++++++++++++
 tb/tb_hp_fetch.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hp_pkg.sv
// Shared types and constants for the hp instruction fetch slice.
package hp_pkg;

  localparam int XLEN = 32;
  localparam int PC_W = 30;

  localparam logic [XLEN-1:0] NOP_INST = 32'h00000013;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  // Word-address increment; wraps naturally at 2^PC_W.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/hp_fifo.sv
// Small show-ahead FIFO with flush; head entry is visible combinationally on pop_data.
module hp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 62,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);

  assign pop_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/hp_fetch.sv
// Instruction fetch stage: sequential imem requests, prefetch buffer, redirect flush.
// Optional HP_FETCH_BYPASS_EN: same-cycle rvalid -> decode path when the buffer is empty.
module hp_fetch
  import hp_pkg::*;
#(
  parameter int              FIFO_DEPTH      = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [PC_W-1:0] RESET_PC        = 30'h0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [XLEN-1:0] inst_o,
  output logic [PC_W-1:0] inst_pc_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CW    = CNT_W + 1;

  logic [PC_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic [PC_W-1:0] resp_pc_reg, resp_pc_next;
  logic [CW-1:0]   outstanding_reg, outstanding_next;
  logic [CW-1:0]   drop_cnt_reg, drop_cnt_next;

  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t    fifo_wdata;
  fetch_entry_t    fifo_rdata;
  fetch_entry_t    head_entry;

  logic [CW-1:0]   credit_used;
  logic            gnt_acc;
  logic            rsp_drop;
  logic            rsp_keep;

  // Live in-flight responses plus buffered entries must leave room for every answer.
  assign credit_used = outstanding_reg - drop_cnt_reg + {1'b0, fifo_count};

  assign imem_req_o  = rst_n & ~redirect_i
                     & (outstanding_reg < CW'(MAX_OUTSTANDING))
                     & (credit_used < CW'(FIFO_DEPTH));
  assign imem_addr_o = fetch_pc_reg;

  assign gnt_acc  = imem_req_o & imem_gnt_i;
  assign rsp_drop = imem_rvalid_i & (drop_cnt_reg != '0);
  assign rsp_keep = imem_rvalid_i & (drop_cnt_reg == '0) & ~redirect_i;

  always_comb begin
    outstanding_next = outstanding_reg;
    if (gnt_acc && !imem_rvalid_i) begin
      outstanding_next = outstanding_reg + CW'(1);
    end else if (!gnt_acc && imem_rvalid_i) begin
      outstanding_next = outstanding_reg - CW'(1);
    end
  end

  always_comb begin
    drop_cnt_next = drop_cnt_reg;
    fetch_pc_next = fetch_pc_reg;
    resp_pc_next  = resp_pc_reg;
    if (redirect_i) begin
      // Everything still in flight after this cycle belongs to the old stream.
      drop_cnt_next = outstanding_next;
      fetch_pc_next = redirect_pc_i;
      resp_pc_next  = redirect_pc_i;
    end else begin
      if (rsp_drop) begin
        drop_cnt_next = drop_cnt_reg - CW'(1);
      end
      if (gnt_acc) begin
        fetch_pc_next = pc_inc(fetch_pc_reg);
      end
      if (rsp_keep) begin
        resp_pc_next = pc_inc(resp_pc_reg);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      resp_pc_reg     <= resp_pc_next;
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;
    end
  end

  assign fifo_wdata.pc   = resp_pc_reg;
  assign fifo_wdata.inst = imem_rdata_i;

`ifdef HP_FETCH_BYPASS_EN
  logic bypass_active;

  assign bypass_active = rsp_keep & fifo_empty;
  assign inst_valid_o  = ~fifo_empty | bypass_active;
  assign head_entry    = fifo_empty ? fifo_wdata : fifo_rdata;
  assign fifo_push     = rsp_keep & ~(bypass_active & inst_ready_i);
`else
  assign inst_valid_o  = ~fifo_empty;
  assign head_entry    = fifo_rdata;
  assign fifo_push     = rsp_keep;
`endif

  assign fifo_pop  = ~fifo_empty & inst_ready_i;
  assign inst_o    = inst_valid_o ? head_entry.inst : '0;
  assign inst_pc_o = inst_valid_o ? head_entry.pc : '0;

  hp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_prefetch (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_i),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // The request credit must make a push into a full, non-draining buffer impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_hp_fetch.sv
// Randomized bench for hp_fetch with a queue-based imem/decode scoreboard.
module tb_hp_fetch;
  import hp_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int MAX_OUT    = 2;

  logic            clk;
  logic            rst_n;
  logic            redirect_i;
  logic [PC_W-1:0] redirect_pc_i;
  logic            imem_req_o;
  logic [PC_W-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [XLEN-1:0] imem_rdata_i;
  logic            inst_valid_o;
  logic            inst_ready_i;
  logic [XLEN-1:0] inst_o;
  logic [PC_W-1:0] inst_pc_o;

  hp_fetch #(
    .FIFO_DEPTH      (FIFO_DEPTH),
    .MAX_OUTSTANDING (MAX_OUT),
    .RESET_PC        (30'h0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_ready_i  (inst_ready_i),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            stale;
  } pend_t;

  int checks = 0;
  int failures = 0;
  int grants = 0;
  logic obs_valid;

  pend_t           pending[$];
  logic [PC_W-1:0] exp_q[$];
  logic [PC_W-1:0] delivered[$];
  logic [PC_W-1:0] fetch_pc_m;

  function automatic logic [XLEN-1:0] mem_word(input logic [PC_W-1:0] a);
    return {a, 2'b01} ^ 32'h5A3C_96E1;
  endfunction

  function automatic int live_count();
    int n = 0;
    foreach (pending[i]) if (!pending[i].stale) n++;
    return n;
  endfunction

  task automatic model_reset();
    pending.delete();
    exp_q.delete();
    fetch_pc_m = 30'h0;
  endtask

  // One clock: drive imem/decode inputs, compare outputs to the model, advance the model.
  task automatic step(input logic redir, input logic [PC_W-1:0] rpc,
                      input int gnt_pct, input int rv_pct, input logic rdy);
    logic  rv, gnt, exp_req, exp_valid;
    pend_t ent;
    @(negedge clk);
    redirect_i    = redir;
    redirect_pc_i = rpc;
    inst_ready_i  = rdy;
    rv = (pending.size() > 0) && (int'($urandom_range(99)) < rv_pct);
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? mem_word(pending[0].pc) : $urandom();
    #1;
    exp_req = !redir && (pending.size() < MAX_OUT) &&
              (live_count() + exp_q.size() < FIFO_DEPTH);
    checks++;
    if (imem_req_o !== exp_req) begin
      failures++;
      $display("FAIL req: got %b expected %b", imem_req_o, exp_req);
    end
    if (exp_req) begin
      checks++;
      if (imem_addr_o !== fetch_pc_m) begin
        failures++;
        $display("FAIL addr: got %h expected %h", imem_addr_o, fetch_pc_m);
      end
    end
    exp_valid = (exp_q.size() > 0);
    obs_valid = inst_valid_o;
    checks++;
    if (inst_valid_o !== exp_valid) begin
      failures++;
      $display("FAIL valid: got %b expected %b", inst_valid_o, exp_valid);
    end
    if (exp_valid) begin
      checks++;
      if (inst_pc_o !== exp_q[0] || inst_o !== mem_word(exp_q[0])) begin
        failures++;
        $display("FAIL head: got pc=%h inst=%h expected pc=%h inst=%h",
                 inst_pc_o, inst_o, exp_q[0], mem_word(exp_q[0]));
      end
    end
    gnt = imem_req_o && (int'($urandom_range(99)) < gnt_pct);
    imem_gnt_i = gnt;
    if (exp_valid && rdy && !redir) begin
      delivered.push_back(exp_q[0]);
      void'(exp_q.pop_front());
    end
    if (rv) begin
      ent = pending.pop_front();
      if (!ent.stale && !redir) exp_q.push_back(ent.pc);
    end
    if (gnt) begin
      ent.pc    = fetch_pc_m;
      ent.stale = 1'b0;
      pending.push_back(ent);
      fetch_pc_m++;
      grants++;
    end
    if (redir) begin
      exp_q.delete();
      foreach (pending[i]) pending[i].stale = 1'b1;
      fetch_pc_m = rpc;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((pending.size() > 0 || exp_q.size() > 0) && n < 50) begin
      step(1'b0, '0, 0, 100, 1'b1);
      n++;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (imem_req_o !== 1'b0 || inst_valid_o !== 1'b0 || inst_o !== '0 || inst_pc_o !== '0) begin
      failures++;
      $display("FAIL %s: got req=%b valid=%b inst=%h pc=%h expected all zero",
               name, imem_req_o, inst_valid_o, inst_o, inst_pc_o);
    end
  endtask

  task automatic check_first_req(input string name);
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 30'h0) begin
      failures++;
      $display("FAIL %s: got req=%b addr=%h expected req=1 addr=0", name, imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0; imem_rdata_i = '0; inst_ready_i = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    #1;
    check_first_req("reset_first_req");
    $display("test_reset done checks=%0d", checks);
  endtask

  task automatic test_stream();
    delivered.delete();
    repeat (20) step(1'b0, '0, 100, 100, 1'b1);
    checks++;
    if (delivered.size() != 18 || delivered[0] !== 30'h0 || delivered[17] !== 30'd17) begin
      failures++;
      $display("FAIL stream: got count=%0d first=%h last=%h expected 18 0 11",
               delivered.size(), delivered.size() ? delivered[0] : 30'h0,
               delivered.size() ? delivered[delivered.size()-1] : 30'h0);
    end
    $display("test_stream delivered=%0d", delivered.size());
  endtask

  task automatic test_gnt_stall();
    repeat (60) step(1'b0, '0, 30, 50, 1'($urandom_range(1)));
    drain();
    $display("test_gnt_stall done checks=%0d", checks);
  endtask

  task automatic test_backpressure(input string name);
    drain();
    grants = 0;
    repeat (10) step(1'b0, '0, 100, 100, 1'b0);
    checks++;
    if (grants != FIFO_DEPTH) begin
      failures++;
      $display("FAIL %s grants: got %0d expected %0d", name, grants, FIFO_DEPTH);
    end
    delivered.delete();
    drain();
    checks++;
    if (delivered.size() != FIFO_DEPTH) begin
      failures++;
      $display("FAIL %s drained: got %0d expected %0d", name, delivered.size(), FIFO_DEPTH);
    end
    $display("test_backpressure %s grants=%0d drained=%0d", name, grants, delivered.size());
  endtask

  task automatic get_two_outstanding(input string name);
    int n = 0;
    drain();
    while (pending.size() < 2 && n < 6) begin
      step(1'b0, '0, 100, 0, 1'b1);
      n++;
    end
    checks++;
    if (pending.size() != 2) begin
      failures++;
      $display("FAIL %s setup: got %0d outstanding expected 2", name, pending.size());
    end
  endtask

  task automatic test_redirect();
    get_two_outstanding("redirect");
    step(1'b1, 30'h100, 100, 0, 1'b1);
    delivered.delete();
    step(1'b0, '0, 100, 100, 1'b1);
    checks++;
    if (obs_valid !== 1'b0) begin
      failures++;
      $display("FAIL redirect_flush: got valid=%b expected 0", obs_valid);
    end
    repeat (10) step(1'b0, '0, 100, 100, 1'b1);
    checks++;
    if (delivered.size() == 0 || delivered[0] !== 30'h100) begin
      failures++;
      $display("FAIL redirect_target: got %h expected 100",
               delivered.size() ? delivered[0] : 30'h3FFFFFFF);
    end
    $display("test_redirect first=%h", delivered.size() ? delivered[0] : 30'h0);
  endtask

  task automatic test_redirect_coincident();
    get_two_outstanding("coincident");
    step(1'b1, 30'h2000, 100, 100, 1'b1);
    delivered.delete();
    repeat (12) step(1'b0, '0, 100, 100, 1'b1);
    checks++;
    if (delivered.size() == 0 || delivered[0] !== 30'h2000) begin
      failures++;
      $display("FAIL coincident_target: got %h expected 2000",
               delivered.size() ? delivered[0] : 30'h3FFFFFFF);
    end
    test_backpressure("coincident_credit");
  endtask

  task automatic test_wrap();
    drain();
    step(1'b1, 30'h3FFFFFFE, 0, 0, 1'b1);
    delivered.delete();
    repeat (10) step(1'b0, '0, 100, 100, 1'b1);
    checks++;
    if (delivered.size() < 3 || delivered[1] !== 30'h3FFFFFFF || delivered[2] !== 30'h0) begin
      failures++;
      $display("FAIL wrap: got %0d entries, [1]=%h [2]=%h expected 3fffffff 0", delivered.size(),
               delivered.size() > 1 ? delivered[1] : 30'h0, delivered.size() > 2 ? delivered[2] : 30'h0);
    end
    $display("test_wrap delivered=%0d", delivered.size());
  endtask

  task automatic test_random();
    delivered.delete();
    for (int i = 0; i < 400; i++) begin
      step(int'($urandom_range(99)) < 3, 30'($urandom()), 60, 60, 1'($urandom_range(1)));
    end
    drain();
    checks++;
    if (delivered.size() == 0) begin
      failures++;
      $display("FAIL random_progress: got 0 deliveries expected >0");
    end
    $display("test_random delivered=%0d", delivered.size());
  endtask

  task automatic test_reset_mid();
    drain();
    repeat (10) step(1'b0, '0, 100, 100, 1'b0);
    @(negedge clk);
    rst_n = 1'b0; redirect_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_first_req("reset_mid_first_req");
    delivered.delete();
    repeat (8) step(1'b0, '0, 100, 100, 1'b1);
    checks++;
    if (delivered.size() == 0 || delivered[0] !== 30'h0) begin
      failures++;
      $display("FAIL reset_mid_restart: got %h expected 0",
               delivered.size() ? delivered[0] : 30'h3FFFFFFF);
    end
    $display("test_reset_mid done checks=%0d", checks);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_gnt_stall();
    test_backpressure("ready_low");
    test_redirect();
    test_redirect_coincident();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
